// File: rtl/dsp_stack.sv
// dsp_stack: hardware data stack with a registered top-of-stack word.
// The TOS lives in a flop so the ALU operand has no RAM path. Deeper
// entries sit in a DEPTH-1 word RAM addressed from the count.
// Optional build macro DSP_STACK_ERR_EN enables the sticky ovf/unf flags.
// Without it, ovf/unf read 0 and clr_err is ignored. Illegal pushes and
// pops are still dropped, so the stack contents stay protected.
module dsp_stack #(
  parameter int NBDATA = 32,
  parameter int SDEPTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [NBDATA-1:0] data_in,
  output logic [NBDATA-1:0] tos,
  output logic [SDEPTH:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf,
  input  logic              clr_err
);

  localparam int DEPTH = 2 ** SDEPTH;
  localparam logic [SDEPTH:0]   CNT_ZERO = '0;
  localparam logic [SDEPTH:0]   CNT_ONE  = (SDEPTH + 1)'(1);
  localparam logic [SDEPTH:0]   CNT_FULL = (SDEPTH + 1)'(DEPTH);
  localparam logic [SDEPTH-1:0] IDX_ONE  = SDEPTH'(1);
  localparam logic [SDEPTH-1:0] IDX_TWO  = SDEPTH'(2);

  logic [NBDATA-1:0] tos_q, tos_d;
  logic [SDEPTH:0]   count_q, count_d;
  logic [NBDATA-1:0] mem_q [0:DEPTH-2];
  logic [SDEPTH-1:0] wr_idx, rd_idx;
  logic [NBDATA-1:0] rd_data;
  logic              mem_we;
  logic              ovf_set, unf_set;
  logic              is_empty, is_full;

  assign is_empty = (count_q == CNT_ZERO);
  assign is_full  = (count_q == CNT_FULL);

  // wr_idx is the next free RAM slot and rd_idx is the word just below
  // the TOS. Only the low bits are used: a write never happens when full,
  // and a read is only consumed when count >= 2.
  assign wr_idx  = count_q[SDEPTH-1:0] - IDX_ONE;
  assign rd_idx  = count_q[SDEPTH-1:0] - IDX_TWO;
  assign rd_data = mem_q[rd_idx];

  // Next-state decode for TOS, count, RAM write and error events
  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    mem_we  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          mem_we  = !is_empty;
          tos_d   = data_in;
          count_d = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else if (count_q == CNT_ONE) begin
          tos_d   = '0;
          count_d = CNT_ZERO;
        end else begin
          tos_d   = rd_data;
          count_d = count_q - CNT_ONE;
        end
      end
      2'b11: begin
        // Replace the TOS in place. On an empty stack this degrades to a push.
        tos_d = data_in;
        if (is_empty) begin
          count_d = CNT_ONE;
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // TOS and occupancy registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q   <= '0;
      count_q <= CNT_ZERO;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  // Spill the old TOS into RAM on a push. The RAM is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= tos_q;
    end
  end

`ifdef DSP_STACK_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A new error event wins over a simultaneous clear
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic unused_err;
  assign unused_err = clr_err ^ ovf_set ^ unf_set;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  assign tos   = tos_q;
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;

endmodule
